// File: rtl/bin_ratio_pkg.sv
// rtl/bin_ratio_pkg.sv - shared types, default sizes and width helpers for the bin-ratio ensemble back-end
package bin_ratio_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        TALLY,
        ARGMAX,
        DONE
    } state_t;

    localparam int DEF_NUM_NETS    = 20;
    localparam int DEF_NUM_CLASSES = 18;
    localparam int DEF_ID_W        = 5;
    localparam int DEF_TIMEOUT     = 65535;

    function automatic int vote_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int tmr_w(input int t);
        return $clog2(t + 1);
    endfunction

    // Index counters need at least one bit even for a single-entry scan.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int VOTE_W = vote_w(DEF_NUM_NETS);
    localparam int TMR_W  = tmr_w(DEF_TIMEOUT);

endpackage

// File: rtl/bin_ratio_ensemble_vote_if.sv
// rtl/bin_ratio_ensemble_vote_if.sv - net-winner collection and ensemble result bundle (ENSEMBLE_CONF_EN adds margin outputs)
interface bin_ratio_ensemble_vote_if #(
    parameter int NUM_NETS = bin_ratio_pkg::DEF_NUM_NETS,
    parameter int ID_W     = bin_ratio_pkg::DEF_ID_W,
    parameter int VOTE_W   = bin_ratio_pkg::VOTE_W
);
    logic                     trans_start;
    logic [NUM_NETS-1:0]      net_ready;
    logic [NUM_NETS*ID_W-1:0] net_winner;
    logic                     request_new_sample;
    logic [ID_W-1:0]          ens_winner;
    logic                     ens_valid;
    logic [VOTE_W-1:0]        ens_votes;
    logic                     timeout_flag;

`ifdef ENSEMBLE_CONF_EN
    logic [VOTE_W-1:0]        ens_margin;
    logic                     ens_low_conf;

    modport master (
        output trans_start, net_ready, net_winner,
        input  request_new_sample, ens_winner, ens_valid, ens_votes, timeout_flag,
               ens_margin, ens_low_conf
    );
    modport slave (
        input  trans_start, net_ready, net_winner,
        output request_new_sample, ens_winner, ens_valid, ens_votes, timeout_flag,
               ens_margin, ens_low_conf
    );
`else
    modport master (
        output trans_start, net_ready, net_winner,
        input  request_new_sample, ens_winner, ens_valid, ens_votes, timeout_flag
    );
    modport slave (
        input  trans_start, net_ready, net_winner,
        output request_new_sample, ens_winner, ens_valid, ens_votes, timeout_flag
    );
`endif

endinterface

// File: rtl/ens_argmax_seq.sv
// rtl/ens_argmax_seq.sv - one-class-per-cycle max scanner over the vote array (ENSEMBLE_CONF_EN adds second-best)
module ens_argmax_seq
    import bin_ratio_pkg::*;
#(
    parameter int NUM_CLASSES = DEF_NUM_CLASSES,
    parameter int VOTE_BITS   = VOTE_W
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic                             i_start,
    input  logic [NUM_CLASSES*VOTE_BITS-1:0] i_votes,
    output logic                             o_done,
    output logic [idx_w(NUM_CLASSES)-1:0]    o_best_idx,
    output logic [VOTE_BITS-1:0]             o_best_cnt
`ifdef ENSEMBLE_CONF_EN
    ,
    output logic [VOTE_BITS-1:0]             o_second_cnt
`endif
);

    localparam int                CIDX_W    = idx_w(NUM_CLASSES);
    localparam logic [CIDX_W-1:0] CIDX_LAST = CIDX_W'(NUM_CLASSES - 1);

    logic                 r_busy;
    logic [CIDX_W-1:0]    r_idx;
    logic [CIDX_W-1:0]    r_best_idx;
    logic [VOTE_BITS-1:0] r_best_cnt;
    logic [VOTE_BITS-1:0] w_cnt;
`ifdef ENSEMBLE_CONF_EN
    logic [VOTE_BITS-1:0] r_second_cnt;
`endif

    assign w_cnt  = i_votes[r_idx*VOTE_BITS +: VOTE_BITS];
    // Asserted during the cycle that examines the last class.
    assign o_done = r_busy && (r_idx == CIDX_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy     <= 1'b0;
            r_idx      <= '0;
            r_best_idx <= '0;
            r_best_cnt <= '0;
`ifdef ENSEMBLE_CONF_EN
            r_second_cnt <= '0;
`endif
        end else if (i_start) begin
            r_busy     <= 1'b1;
            r_idx      <= '0;
            r_best_idx <= '0;
            r_best_cnt <= '0;
`ifdef ENSEMBLE_CONF_EN
            r_second_cnt <= '0;
`endif
        end else if (r_busy) begin
            // Strictly greater keeps the lowest index on ties.
            if (w_cnt > r_best_cnt) begin
                r_best_cnt <= w_cnt;
                r_best_idx <= r_idx;
`ifdef ENSEMBLE_CONF_EN
                r_second_cnt <= r_best_cnt;
            end else if (w_cnt > r_second_cnt) begin
                r_second_cnt <= w_cnt;
`endif
            end
            r_idx <= r_idx + 1'b1;
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_best_idx = r_best_idx;
    assign o_best_cnt = r_best_cnt;
`ifdef ENSEMBLE_CONF_EN
    assign o_second_cnt = r_second_cnt;
`endif

endmodule

// File: rtl/bin_ratio_ensemble_vote.sv
// rtl/bin_ratio_ensemble_vote.sv - ensemble majority vote with per-sample timeout (ENSEMBLE_CONF_EN adds confidence margin)
module bin_ratio_ensemble_vote
    import bin_ratio_pkg::*;
#(
    parameter int NUM_NETS    = DEF_NUM_NETS,
    parameter int NUM_CLASSES = DEF_NUM_CLASSES,
    parameter int ID_W        = DEF_ID_W,
    parameter int TIMEOUT     = DEF_TIMEOUT
`ifdef ENSEMBLE_CONF_EN
    ,
    parameter int CONF_MARGIN = 2
`endif
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    bin_ratio_ensemble_vote_if.slave bus
);

    localparam int VOTE_BITS = vote_w(NUM_NETS);
    localparam int TMR_BITS  = tmr_w(TIMEOUT);
    localparam int NIDX_W    = idx_w(NUM_NETS);
    localparam int CIDX_W    = idx_w(NUM_CLASSES);

    localparam logic [TMR_BITS-1:0] TMR_LAST  = TMR_BITS'(TIMEOUT - 1);
    localparam logic [NIDX_W-1:0]   NIDX_LAST = NIDX_W'(NUM_NETS - 1);
    localparam logic [ID_W:0]       NCLS      = (ID_W + 1)'(NUM_CLASSES);

    state_t                 r_state;
    logic [NUM_NETS-1:0]    r_got;
    logic [ID_W-1:0]        r_buf  [NUM_NETS];
    logic [VOTE_BITS-1:0]   r_vote [NUM_CLASSES];
    logic [TMR_BITS-1:0]    r_tmr;
    logic [NIDX_W-1:0]      r_nidx;
    logic                   r_tflag;
    logic                   r_req;
    logic                   r_valid;
    logic [ID_W-1:0]        r_win;
    logic [VOTE_BITS-1:0]   r_votes;
    logic                   r_tout;
`ifdef ENSEMBLE_CONF_EN
    logic [VOTE_BITS-1:0]   r_margin;
    logic                   r_low_conf;
    logic [VOTE_BITS-1:0]   w_second_cnt;
    logic [VOTE_BITS-1:0]   w_margin;
`endif

    logic [NUM_NETS-1:0]              w_take;
    logic [NUM_NETS-1:0]              w_got_nx;
    logic [ID_W-1:0]                  w_cur_id;
    logic                             w_cur_ok;
    logic                             w_am_start;
    logic                             w_am_done;
    logic [CIDX_W-1:0]                w_best_idx;
    logic [VOTE_BITS-1:0]             w_best_cnt;
    logic [NUM_CLASSES*VOTE_BITS-1:0] w_vote_flat;

    // First ready per net wins; later readies from a latched net are ignored.
    assign w_take     = bus.net_ready & ~r_got;
    assign w_got_nx   = r_got | bus.net_ready;
    assign w_cur_id   = r_buf[r_nidx];
    assign w_cur_ok   = r_got[r_nidx] && ({1'b0, w_cur_id} < NCLS);
    assign w_am_start = (r_state == TALLY) && (r_nidx == NIDX_LAST);

    always_comb begin
        w_vote_flat = '0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            w_vote_flat[c*VOTE_BITS +: VOTE_BITS] = r_vote[c];
        end
    end

    ens_argmax_seq #(
        .NUM_CLASSES (NUM_CLASSES),
        .VOTE_BITS   (VOTE_BITS)
    ) u_argmax (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (w_am_start),
        .i_votes      (w_vote_flat),
        .o_done       (w_am_done),
        .o_best_idx   (w_best_idx),
        .o_best_cnt   (w_best_cnt)
`ifdef ENSEMBLE_CONF_EN
        ,
        .o_second_cnt (w_second_cnt)
`endif
    );

`ifdef ENSEMBLE_CONF_EN
    assign w_margin = w_best_cnt - w_second_cnt;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_req   <= 1'b1;
            r_got   <= '0;
            r_tmr   <= '0;
            r_nidx  <= '0;
            r_tflag <= 1'b0;
            r_valid <= 1'b0;
            r_win   <= '0;
            r_votes <= '0;
            r_tout  <= 1'b0;
            for (int i = 0; i < NUM_NETS; i++) begin
                r_buf[i] <= '0;
            end
            for (int c = 0; c < NUM_CLASSES; c++) begin
                r_vote[c] <= '0;
            end
`ifdef ENSEMBLE_CONF_EN
            r_margin   <= '0;
            r_low_conf <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.trans_start) begin
                        r_got <= '0;
                        r_tmr <= '0;
                        for (int c = 0; c < NUM_CLASSES; c++) begin
                            r_vote[c] <= '0;
                        end
                        r_req   <= 1'b0;
                        r_state <= COLLECT;
                    end else begin
                        r_req <= 1'b1;
                    end
                end
                COLLECT: begin
                    for (int i = 0; i < NUM_NETS; i++) begin
                        if (w_take[i]) begin
                            r_buf[i] <= bus.net_winner[i*ID_W +: ID_W];
                        end
                    end
                    r_got  <= w_got_nx;
                    r_tmr  <= r_tmr + 1'b1;
                    r_nidx <= '0;
                    if (&w_got_nx) begin
                        r_tflag <= 1'b0;
                        r_state <= TALLY;
                    end else if (r_tmr == TMR_LAST) begin
                        r_tflag <= 1'b1;
                        r_state <= TALLY;
                    end
                end
                TALLY: begin
                    if (w_cur_ok) begin
                        r_vote[w_cur_id] <= r_vote[w_cur_id] + 1'b1;
                    end
                    r_nidx <= r_nidx + 1'b1;
                    if (r_nidx == NIDX_LAST) begin
                        r_state <= ARGMAX;
                    end
                end
                ARGMAX: begin
                    if (w_am_done) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_win   <= ID_W'(w_best_idx);
                    r_votes <= w_best_cnt;
                    r_tout  <= r_tflag;
                    r_valid <= 1'b1;
`ifdef ENSEMBLE_CONF_EN
                    r_margin   <= w_margin;
                    r_low_conf <= ({{(32-VOTE_BITS){1'b0}}, w_margin} < CONF_MARGIN);
`endif
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.request_new_sample = r_req;
    assign bus.ens_winner         = r_win;
    assign bus.ens_valid          = r_valid;
    assign bus.ens_votes          = r_votes;
    assign bus.timeout_flag       = r_tout;
`ifdef ENSEMBLE_CONF_EN
    assign bus.ens_margin         = r_margin;
    assign bus.ens_low_conf       = r_low_conf;
`endif

endmodule

// File: tb/tb_bin_ratio_ensemble_vote.sv
// tb/tb_bin_ratio_ensemble_vote.sv - randomized self-checking bench for bin_ratio_ensemble_vote (honours ENSEMBLE_CONF_EN)
module tb_bin_ratio_ensemble_vote;
    import bin_ratio_pkg::*;

    localparam int NN = 4;
    localparam int NC = 5;
    localparam int IW = 3;
    localparam int TO = 50;
    localparam int VW = vote_w(NN);
`ifdef ENSEMBLE_CONF_EN
    localparam int CM = 2;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bin_ratio_ensemble_vote_if #(.NUM_NETS(NN), .ID_W(IW), .VOTE_W(VW)) bus ();

    bin_ratio_ensemble_vote #(
        .NUM_NETS    (NN),
        .NUM_CLASSES (NC),
        .ID_W        (IW),
        .TIMEOUT     (TO)
`ifdef ENSEMBLE_CONF_EN
        ,
        .CONF_MARGIN (CM)
`endif
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int total = 0;
    int bad = 0;
    int n_valid = 0;
    int ev_cyc[NN][2];
    int ev_val[NN][2];
    int ts_inject;
    bit chk_busy;

    always @(negedge clk) if (bus.ens_valid === 1'b1) n_valid++;

    task automatic clear_ev();
        for (int i = 0; i < NN; i++) begin
            ev_cyc[i][0] = -1; ev_cyc[i][1] = -1;
            ev_val[i][0] = 0;  ev_val[i][1] = 0;
        end
        ts_inject = -1;
        chk_busy = 1'b0;
    endtask

    task automatic drive_cycle(input int j);
        logic [NN-1:0]    rdy;
        logic [NN*IW-1:0] win;
        rdy = '0;
        win = (NN*IW)'($urandom);
        for (int i = 0; i < NN; i++) begin
            for (int e = 0; e < 2; e++) begin
                if (ev_cyc[i][e] == j) begin
                    rdy[i] = 1'b1;
                    win[i*IW +: IW] = IW'(ev_val[i][e]);
                end
            end
        end
        bus.net_ready   = rdy;
        bus.net_winner  = win;
        bus.trans_start = (j == ts_inject);
    endtask

    task automatic check_idle_outputs(input string name);
        total++; if (bus.request_new_sample !== 1'b1) begin bad++; $display("FAIL %s request got=%b want=1", name, bus.request_new_sample); end
        total++; if (bus.ens_winner !== '0) begin bad++; $display("FAIL %s winner got=%0d want=0", name, bus.ens_winner); end
        total++; if (bus.ens_votes !== '0) begin bad++; $display("FAIL %s votes got=%0d want=0", name, bus.ens_votes); end
        total++; if (bus.ens_valid !== 1'b0) begin bad++; $display("FAIL %s valid got=%b want=0", name, bus.ens_valid); end
        total++; if (bus.timeout_flag !== 1'b0) begin bad++; $display("FAIL %s tflag got=%b want=0", name, bus.timeout_flag); end
`ifdef ENSEMBLE_CONF_EN
        total++; if (bus.ens_margin !== '0 || bus.ens_low_conf !== 1'b0) begin bad++; $display("FAIL %s conf got=%0d/%b want=0/0", name, bus.ens_margin, bus.ens_low_conf); end
`endif
    endtask

    // Reference: first ready per net inside the window, plain vote counting, lowest-index argmax.
    task automatic run_and_check(input string name);
        int first[NN];
        int fval[NN];
        int cnt[NC];
        bit all;
        int exit_k, b_idx, b_cnt, s_cnt, exp_j, obs_j, v0;
        all = 1'b1; exit_k = 0;
        for (int i = 0; i < NN; i++) begin
            first[i] = -1; fval[i] = 0;
            for (int e = 0; e < 2; e++) begin
                if (ev_cyc[i][e] >= 0 && ev_cyc[i][e] < TO && (first[i] < 0 || ev_cyc[i][e] < first[i])) begin
                    first[i] = ev_cyc[i][e]; fval[i] = ev_val[i][e];
                end
            end
            if (first[i] < 0) all = 1'b0;
            else if (first[i] > exit_k) exit_k = first[i];
        end
        if (!all) exit_k = TO - 1;
        for (int c = 0; c < NC; c++) cnt[c] = 0;
        for (int i = 0; i < NN; i++) if (first[i] >= 0 && fval[i] < NC) cnt[fval[i]]++;
        b_idx = 0; b_cnt = cnt[0];
        for (int c = 1; c < NC; c++) if (cnt[c] > b_cnt) begin b_cnt = cnt[c]; b_idx = c; end
        s_cnt = 0;
        for (int c = 0; c < NC; c++) if (c != b_idx && cnt[c] > s_cnt) s_cnt = cnt[c];
        exp_j = exit_k + 1 + NN + NC + 1;

        @(negedge clk);
        #1 v0 = n_valid;
        total++; if (bus.request_new_sample !== 1'b1) begin bad++; $display("FAIL %s req_idle got=%b want=1", name, bus.request_new_sample); end
        bus.trans_start = 1'b1;
        @(negedge clk);
        bus.trans_start = 1'b0;
        total++; if (bus.request_new_sample !== 1'b0) begin bad++; $display("FAIL %s req_busy got=%b want=0", name, bus.request_new_sample); end
        obs_j = -1;
        for (int j = 0; j < TO + NN + NC + 20 && obs_j < 0; j++) begin
            drive_cycle(j);
            @(negedge clk);
            if (bus.ens_valid === 1'b1) obs_j = j + 1;
        end
        bus.net_ready = '0; bus.trans_start = 1'b0;
        total++; if (obs_j != exp_j) begin bad++; $display("FAIL %s latency got=%0d want=%0d", name, obs_j, exp_j); end
        total++; if (bus.ens_winner !== IW'(b_idx)) begin bad++; $display("FAIL %s winner got=%0d want=%0d", name, bus.ens_winner, b_idx); end
        total++; if (bus.ens_votes !== VW'(b_cnt)) begin bad++; $display("FAIL %s votes got=%0d want=%0d", name, bus.ens_votes, b_cnt); end
        total++; if (bus.timeout_flag !== !all) begin bad++; $display("FAIL %s tflag got=%b want=%b", name, bus.timeout_flag, !all); end
        total++; if (bus.request_new_sample !== 1'b0) begin bad++; $display("FAIL %s req_at_valid got=%b want=0", name, bus.request_new_sample); end
`ifdef ENSEMBLE_CONF_EN
        total++; if (bus.ens_margin !== VW'(b_cnt - s_cnt)) begin bad++; $display("FAIL %s margin got=%0d want=%0d", name, bus.ens_margin, b_cnt - s_cnt); end
        total++; if (bus.ens_low_conf !== ((b_cnt - s_cnt) < CM)) begin bad++; $display("FAIL %s low_conf got=%b want=%b", name, bus.ens_low_conf, (b_cnt - s_cnt) < CM); end
`endif
        @(negedge clk);
        total++; if (bus.ens_valid !== 1'b0) begin bad++; $display("FAIL %s valid_width got=%b want=0", name, bus.ens_valid); end
        total++; if (bus.request_new_sample !== 1'b1) begin bad++; $display("FAIL %s req_after got=%b want=1", name, bus.request_new_sample); end
        total++; if (bus.ens_winner !== IW'(b_idx)) begin bad++; $display("FAIL %s winner_hold got=%0d want=%0d", name, bus.ens_winner, b_idx); end
        if (chk_busy) repeat (TO + NN + NC + 5) @(negedge clk);
        #1;
        total++; if (n_valid - v0 != 1) begin bad++; $display("FAIL %s pulses got=%0d want=1", name, n_valid - v0); end
    endtask

    task automatic set_ev(input int i, input int c0, input int v0, input int c1, input int v1);
        ev_cyc[i][0] = c0; ev_val[i][0] = v0;
        ev_cyc[i][1] = c1; ev_val[i][1] = v1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.trans_start = 1'b0; bus.net_ready = '0; bus.net_winner = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        clear_ev();
        set_ev(0, 0, 3, -1, 0); set_ev(1, 2, 3, -1, 0);
        set_ev(2, 5, 1, -1, 0); set_ev(3, 3, 3, -1, 0);
        run_and_check("basic");
    endtask

    task automatic test_tie();
        clear_ev();
        set_ev(0, 1, 2, -1, 0); set_ev(1, 1, 4, -1, 0);
        set_ev(2, 1, 4, -1, 0); set_ev(3, 1, 2, -1, 0);
        run_and_check("tie");
    endtask

    task automatic test_timeout();
        clear_ev();
        set_ev(0, 4, 1, -1, 0); set_ev(1, 7, 1, -1, 0);
        run_and_check("timeout");
    endtask

    task automatic test_zero_votes();
        clear_ev();
        run_and_check("zero");
    endtask

    task automatic test_invalid_dup();
        clear_ev();
        set_ev(0, 0, 7, -1, 0); set_ev(1, 1, 0, 3, 4);
        set_ev(2, 2, 4, -1, 0); set_ev(3, 4, 0, -1, 0);
        run_and_check("invalid_dup");
    endtask

    task automatic test_busy_ignore();
        clear_ev();
        for (int i = 0; i < NN; i++) set_ev(i, 0, $urandom_range(0, NC - 1), -1, 0);
        ts_inject = 2;
        chk_busy = 1'b1;
        run_and_check("busy");
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            clear_ev();
            for (int i = 0; i < NN; i++) begin
                int c0;
                c0 = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 55);
                set_ev(i, c0, $urandom_range(0, 7),
                       (c0 >= 0 && $urandom_range(0, 2) == 0) ? c0 + $urandom_range(1, 5) : -1,
                       $urandom_range(0, 7));
            end
            run_and_check("random");
        end
    endtask

    task automatic test_mid_reset();
        int v0;
        clear_ev();
        for (int i = 0; i < NN; i++) set_ev(i, 0, $urandom_range(0, NC - 1), -1, 0);
        @(negedge clk);
        bus.trans_start = 1'b1;
        @(negedge clk);
        bus.trans_start = 1'b0;
        drive_cycle(0);
        @(negedge clk);
        bus.net_ready = '0;
        repeat (6) @(negedge clk);
        #1 v0 = n_valid;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        #1;
        total++; if (n_valid != v0) begin bad++; $display("FAIL mid_reset pulses got=%0d want=0", n_valid - v0); end
        clear_ev();
        for (int i = 0; i < NN; i++) set_ev(i, i, $urandom_range(0, 7), -1, 0);
        run_and_check("after_reset");
    endtask

    initial begin
        clear_ev();
        test_reset();
        test_basic();
        test_tie();
        test_timeout();
        test_zero_votes();
        test_invalid_dup();
        test_busy_ignore();
        test_random();
        test_basic();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bin_ratio_ensemble_vote.md
Name: bin_ratio_ensemble_vote

Overview:
Parametrised ensemble back-end for the bin-ratio spiking classifier.
- Collects the winner ID from NUM_NETS parallel bin-ratio spiking nets. Each net uses a different diagonal and runs preprocessing, spike generation and integrate-no-fire.
- Tallies one vote per net and outputs the majority class with a valid pulse.
- Owns the sample-request handshake toward the bin-count source.
- Adds a per-sample timeout, so one stalled net cannot hang inference.

Parameters:
- NUM_NETS, 20: number of ensemble members, range 1..32.
- NUM_CLASSES, 18: number of output classes; valid IDs are 0..NUM_CLASSES-1.
- ID_W, 5: width of each winner ID; requires 2^ID_W >= NUM_CLASSES.
- TIMEOUT, 65535: maximum number of COLLECT cycles before a forced tally; must be >= 1.
- CONF_MARGIN, 2: low-confidence threshold, used only when the optional feature is compiled in.

Ports:
- clk, in, 1: system clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- trans_start, in, 1: one-cycle pulse marking the start of a new sample; same pulse that starts the nets.
- net_ready, in, NUM_NETS: per-net infer_ready; level or pulse both accepted.
- net_winner, in, NUM_NETS*ID_W: per-net winner_ID; net i occupies bits [i*ID_W +: ID_W].
- request_new_sample, out, 1: high while idle and ready to accept trans_start.
- ens_winner, out, ID_W: ensemble class; holds until the next result.
- ens_valid, out, 1: one-cycle pulse when ens_winner updates.
- ens_votes, out, clog2(NUM_NETS+1): vote count of the winning class.
- timeout_flag, out, 1: set with ens_valid if the last sample timed out; holds until the next result.

Behaviour:
- Reset values: state IDLE; request_new_sample=1; ens_winner=0; ens_valid=0; ens_votes=0; timeout_flag=0; got mask, vote counters and timer all cleared. Reset mid-operation aborts immediately, with no partial ens_valid.
- IDLE: request_new_sample=1. When trans_start=1, on that edge: clear got[], all vote counters and the timer; go to COLLECT; request_new_sample drops next cycle.
- COLLECT:
  - Each cycle, every net i with net_ready[i]=1 and got[i]=0 has its net_winner slice latched into buf[i], and got[i] is set.
  - Multiple nets may latch in the same cycle.
  - A repeated ready from an already-latched net is ignored; the first value wins.
  - The timer increments every cycle.
  - When got is all ones (including the cycle of the last latch), go to TALLY with tflag=0.
  - Otherwise, when the timer reaches TIMEOUT-1, go to TALLY with tflag=1. Readies arriving in that same cycle are still latched.
- TALLY: one net per cycle, index 0..NUM_NETS-1 (NUM_NETS cycles). If got[i]=1 and buf[i]<NUM_CLASSES, increment vote[buf[i]]. Out-of-range IDs are discarded silently.
- ARGMAX:
  - One class per cycle, index 0..NUM_CLASSES-1 (NUM_CLASSES cycles).
  - Replace the best candidate only on strictly greater count, so ties resolve to the lowest class index.
  - With zero votes in total, the winner is 0 and the count is 0.
- DONE: one cycle. Register ens_winner, ens_votes and timeout_flag=tflag; pulse ens_valid=1; go to IDLE.
- Latency from the last-latch edge to ens_valid high: NUM_NETS + NUM_CLASSES + 1 cycles.
- trans_start outside IDLE is ignored; no queuing.
- Counter widths: vote counters clog2(NUM_NETS+1); timer clog2(TIMEOUT+1); all saturate by construction, so no wrap.

Optional Feature:
- Macro ENSEMBLE_CONF_EN.
- Defined:
  - Extra outputs ens_margin (clog2(NUM_NETS+1) bits) and ens_low_conf (1 bit), both registered in DONE. Reset 0.
  - ARGMAX also tracks the second-highest count; ens_margin = best - second.
  - ens_low_conf = (ens_margin < CONF_MARGIN).
  - With NUM_CLASSES=1, second = 0.
- Undefined: these ports and the second-best logic are absent. All other behaviour is identical.

Decomposition:
- Shared package bin_ratio_pkg:
  - state enum (IDLE, COLLECT, TALLY, ARGMAX, DONE)
  - localparam width helpers: VOTE_W=clog2(NUM_NETS+1), TMR_W
  - default NUM_CLASSES and ID_W constants
- One sub-module, ens_argmax_seq:
  - Sequential max/second-max scanner over the vote array.
  - Ports: start, done, best_idx, best_cnt, and second_cnt under ENSEMBLE_CONF_EN.
- FSM, collect latch and tally stay in the top.

Test Plan:
1. Test config NUM_NETS=4, NUM_CLASSES=5, TIMEOUT=50. Pulse trans_start; nets report 3,3,1,3 on staggered cycles. Required: ens_winner=3, ens_votes=3, timeout_flag=0; ens_valid exactly 10 cycles after the last ready; request_new_sample returns high the cycle after.
2. Tie: winners 2,4,4,2 all in the same cycle. Required: ens_winner=2, ens_votes=2; under ENSEMBLE_CONF_EN, ens_margin=0 and ens_low_conf=1.
3. Timeout: only nets 0 and 1 report (both 1). Required: ens_valid at COLLECT cycle 50 + 10; ens_winner=1, ens_votes=2, timeout_flag=1.
4. Invalid and duplicate inputs: net 0 reports 7 (out of range); net 1 asserts ready twice with 0 then 4; nets 2 and 3 report 4 and 0. Required: net 1 counts as 0; ens_winner=0, ens_votes=2.
5. Zero votes or busy: no readies until timeout. Required: ens_winner=0, ens_votes=0, timeout_flag=1. Separately, trans_start during TALLY is ignored and yields exactly one ens_valid.
6. Reset: assert rst_n=0 in ARGMAX. Required: all outputs take reset values immediately and no ens_valid pulse occurs; a fresh sample after reset classifies correctly.
